cla_nibble_seq: RTL

//  Multi-nibble operand sequencer that sits around the 4-bit registered-input CLA adder.

---
 rtl/cla_nibble_seq_if.sv | 41 ++++
 rtl/cla_nibble_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq_if.sv
// Upstream, adder-side and downstream signals of cla_nibble_seq.
// The out_ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_nibble_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CLA_SEQ_OVF_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/cla_nibble_seq.sv
// Sequences WIDTH-bit additions through an external 4-bit registered-input CLA, one nibble
// per two cycles, LSB first. Define CLA_SEQ_OVF_EN to add the two's-complement out_ovf flag.
module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  cla_nibble_seq_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d, sum_nxt;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             carry_q, carry_d;
  logic [3:0]       add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_cout_q, out_cout_d;
  logic             ovf_q, ovf_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    ovf_d       = ovf_q;
    idx_nxt     = idx_q + IDX_W'(1);
    sum_nxt     = sum_q;
    sum_nxt[{idx_q, 2'b00} +: 4] = bus.add_s;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          carry_d    = bus.in_cin;
          idx_d      = '0;
          sum_d      = '0;
          add_a_d    = bus.in_a[3:0];
          add_b_d    = bus.in_b[3:0];
          add_cin_d  = bus.in_cin;
          in_ready_d = 1'b0;
          state_d    = ISSUE;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = CAPT;
      end
      CAPT: begin
        // add_a/add_b/add_cin stay put here; the adder's S depends on add_cin combinationally.
        sum_d   = sum_nxt;
        carry_d = bus.add_cout;
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
          out_sum_d   = sum_nxt;
          out_cout_d  = bus.add_cout;
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
          state_d     = DONE;
        end else begin
          idx_d     = idx_nxt;
          add_a_d   = a_q[{idx_nxt, 2'b00} +: 4];
          add_b_d   = b_q[{idx_nxt, 2'b00} +: 4];
          add_cin_d = bus.add_cout;
          state_d   = ISSUE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      add_a_q     <= 4'h0;
      add_b_q     <= 4'h0;
      add_cin_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign bus.out_ovf   = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule
